// File: rtl/uart_rx_core.sv
// UART receiver: 5-8 data bits, optional even/odd parity, 1 or 2 stop bits, one-entry holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        cfg_en,
  input  logic [1:0]  cfg_data_bits,
  input  logic        cfg_stop_bits,
  input  logic        cfg_parity_en,
  input  logic        cfg_even_odd,
  input  logic [15:0] cfg_divisor,
  input  logic        rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_perr,
  output logic        rx_ferr,
  output logic        rx_overrun,
  output logic        rx_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t                 state_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rxd_s;
  logic                   rxd_prev_reg;
  // 17 bits so the full period 2*divisor+1 never wraps
  logic [16:0]            cnt_reg;
  logic [16:0]            full_lat_reg;
  logic [1:0]             dbits_lat_reg;
  logic                   stop2_lat_reg;
  logic                   par_en_lat_reg;
  logic                   even_lat_reg;
  logic [2:0]             bit_idx_reg;
  logic [7:0]             shift_reg;
  logic                   par_acc_reg;
  logic                   perr_reg;
  logic                   ferr_reg;
  logic [7:0]             rx_data_reg;
  logic                   rx_valid_reg;
  logic                   rx_perr_reg;
  logic                   rx_ferr_reg;
  logic                   rx_overrun_reg;

  logic tick;
  logic sample_valid;
  logic sample_bit;
  logic last_bit;
  logic deliver;
  logic deliver_ferr;

  assign rxd_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge mclk) begin
    if (rst) begin
      sync_reg     <= '1;
      rxd_prev_reg <= 1'b1;
    end else begin
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], rxd};
      rxd_prev_reg <= rxd_s;
    end
  end

  assign tick     = (state_reg != S_IDLE) && (cnt_reg == 17'd0);
  assign last_bit = (bit_idx_reg == ({1'b0, dbits_lat_reg} + 3'd4));

`ifdef UART_RX_MAJORITY_EN
  logic s_m1_reg;
  logic s_0_reg;
  logic tick_d_reg;
  logic maj_on;

  // A zero divisor leaves no room for neighbouring samples, so use the centre one
  assign maj_on = (full_lat_reg != 17'd1);

  always_ff @(posedge mclk) begin
    if (rst) begin
      s_m1_reg   <= 1'b1;
      s_0_reg    <= 1'b1;
      tick_d_reg <= 1'b0;
    end else begin
      if (cnt_reg == 17'd1) s_m1_reg <= rxd_s;
      if (tick)             s_0_reg  <= rxd_s;
      tick_d_reg <= tick && cfg_en;
    end
  end

  assign sample_valid = (state_reg != S_IDLE) && (maj_on ? tick_d_reg : tick);
  assign sample_bit   = maj_on ? ((s_m1_reg & s_0_reg) | (s_m1_reg & rxd_s) | (s_0_reg & rxd_s))
                               : rxd_s;
`else
  assign sample_valid = tick;
  assign sample_bit   = rxd_s;
`endif

  assign deliver      = sample_valid && cfg_en &&
                        (((state_reg == S_STOP1) && !stop2_lat_reg) || (state_reg == S_STOP2));
  assign deliver_ferr = ferr_reg | ~sample_bit;

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      full_lat_reg   <= '0;
      dbits_lat_reg  <= '0;
      stop2_lat_reg  <= 1'b0;
      par_en_lat_reg <= 1'b0;
      even_lat_reg   <= 1'b0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      par_acc_reg    <= 1'b0;
      perr_reg       <= 1'b0;
      ferr_reg       <= 1'b0;
    end else if ((state_reg != S_IDLE) && !cfg_en) begin
      state_reg <= S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // Edge-triggered start: a line parked low never restarts a frame
          if (cfg_en && rxd_prev_reg && !rxd_s) begin
            state_reg      <= S_START;
            cnt_reg        <= {1'b0, cfg_divisor};
            full_lat_reg   <= {cfg_divisor, 1'b1};
            dbits_lat_reg  <= cfg_data_bits;
            stop2_lat_reg  <= cfg_stop_bits;
            par_en_lat_reg <= cfg_parity_en;
            even_lat_reg   <= cfg_even_odd;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            par_acc_reg    <= 1'b0;
            perr_reg       <= 1'b0;
            ferr_reg       <= 1'b0;
          end
        end
        default: begin
          cnt_reg <= tick ? full_lat_reg : cnt_reg - 17'd1;
          if (sample_valid) begin
            case (state_reg)
              S_START: begin
                state_reg   <= sample_bit ? S_IDLE : S_DATA;
                bit_idx_reg <= '0;
              end
              S_DATA: begin
                shift_reg[bit_idx_reg] <= sample_bit;
                par_acc_reg            <= par_acc_reg ^ sample_bit;
                if (last_bit) state_reg <= par_en_lat_reg ? S_PARITY : S_STOP1;
                else          bit_idx_reg <= bit_idx_reg + 3'd1;
              end
              S_PARITY: begin
                perr_reg  <= even_lat_reg ? (par_acc_reg != sample_bit) : (par_acc_reg == sample_bit);
                state_reg <= S_STOP1;
              end
              S_STOP1: begin
                ferr_reg  <= ~sample_bit;
                state_reg <= stop2_lat_reg ? S_STOP2 : S_IDLE;
              end
              S_STOP2: begin
                ferr_reg  <= ferr_reg | ~sample_bit;
                state_reg <= S_IDLE;
              end
              default: state_reg <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // Holding register: a full, unaccepted slot drops the new character
  always_ff @(posedge mclk) begin
    if (rst) begin
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      rx_perr_reg    <= 1'b0;
      rx_ferr_reg    <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else begin
      rx_overrun_reg <= 1'b0;
      if (deliver) begin
        if (rx_valid_reg && !rx_ready) begin
          rx_overrun_reg <= 1'b1;
        end else begin
          rx_data_reg  <= shift_reg;
          rx_perr_reg  <= perr_reg;
          rx_ferr_reg  <= deliver_ferr;
          rx_valid_reg <= 1'b1;
        end
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign rx_perr    = rx_perr_reg;
  assign rx_ferr    = rx_ferr_reg;
  assign rx_overrun = rx_overrun_reg;
  assign rx_busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: serial agent, spec-level character model, per-scenario tasks.
module tb_uart_rx_core;

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic        mclk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_en = 1'b1;
  logic [1:0]  cfg_data_bits = 2'd3;
  logic        cfg_stop_bits = 1'b0;
  logic        cfg_parity_en = 1'b0;
  logic        cfg_even_odd = 1'b0;
  logic [15:0] cfg_divisor = 16'd3;
  logic        rxd = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_perr;
  logic        rx_ferr;
  logic        rx_overrun;
  logic        rx_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int ovr_cnt = 0;
  int cur_t = 8;
  int cur_h = 3;

  always #5 mclk = ~mclk;

  uart_rx_core #(.SYNC_STAGES(2)) dut (
    .mclk(mclk), .rst(rst), .cfg_en(cfg_en), .cfg_data_bits(cfg_data_bits),
    .cfg_stop_bits(cfg_stop_bits), .cfg_parity_en(cfg_parity_en), .cfg_even_odd(cfg_even_odd),
    .cfg_divisor(cfg_divisor), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_overrun(rx_overrun),
    .rx_busy(rx_busy)
  );

  always @(negedge mclk) if (rx_overrun === 1'b1) ovr_cnt++;

  // ---------------- reference model ----------------
  function automatic int ones(input logic [7:0] d);
    int c = 0;
    for (int i = 0; i < 8; i++) if (d[i]) c++;
    return c;
  endfunction

  function automatic logic [7:0] model_data(input logic [7:0] d, input int nbits);
    logic [7:0] m;
    m = 8'((1 << nbits) - 1);
    return d & m;
  endfunction

  // Even parity wants an even total of ones (data + parity bit), odd wants an odd total
  function automatic logic model_perr(input logic [7:0] d, input bit par_en, input bit even, input logic p);
    if (!par_en) return 1'b0;
    return ((ones(d) + int'(p)) % 2) != (even ? 0 : 1);
  endfunction

  // ---------------- agent ----------------
  task automatic hold_line(input logic b, input int cycles);
    rxd = b;
    repeat (cycles) @(negedge mclk);
  endtask

  task automatic set_cfg(input int nbits, input bit par_en, input bit even, input bit two_stop, input int div);
    cfg_data_bits = 2'(nbits - 5);
    cfg_parity_en = par_en;
    cfg_even_odd  = even;
    cfg_stop_bits = two_stop;
    cfg_divisor   = 16'(div);
    cur_t = 2 * (div + 1);
    cur_h = div;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en, input bit even,
                            input bit two_stop, input bit bad_par, input bit bad_stop, output logic p);
    p = 1'b0;
    hold_line(1'b0, cur_t);
    for (int i = 0; i < nbits; i++) hold_line(d[i], cur_t);
    if (par_en) begin
      p = even ? logic'(ones(model_data(d, nbits)) % 2) : logic'(1 - ones(model_data(d, nbits)) % 2);
      if (bad_par) p = ~p;
      hold_line(p, cur_t);
    end
    hold_line(~bad_stop, cur_t);
    if (two_stop) hold_line(~bad_stop, cur_t);
    rxd = 1'b1;
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (rx_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge mclk);
    end
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    @(negedge mclk);
    rx_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge mclk);
    n_cmp++; if ({rx_data, rx_valid, rx_perr, rx_ferr, rx_overrun, rx_busy} !== 13'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 0", {rx_data, rx_valid, rx_perr, rx_ferr, rx_overrun, rx_busy});
    end
    rst = 1'b0;
    hold_line(1'b1, 4);
    n_cmp++; if ({rx_valid, rx_busy} !== 2'b00) begin
      n_bad++; $display("FAIL reset_release: valid/busy got %b want 00", {rx_valid, rx_busy});
    end
  endtask

  task automatic test_basic_8n1();
    int n;
    int exp_lat;
    logic p;
    set_cfg(8, 0, 0, 0, 3);
    hold_line(1'b1, 2 * cur_t);
    exp_lat = cur_h + 4 + 9 * cur_t + MAJ;
    n = 0;
    fork
      send_frame(8'hA5, 8, 0, 0, 0, 0, 0, p);
      begin
        while (n < 400 && rx_valid !== 1'b1) begin @(negedge mclk); n++; end
      end
    join
    $display("basic rx %h perr=%0d ferr=%0d latency=%0d", rx_data, rx_perr, rx_ferr, n);
    n_cmp++; if (n != exp_lat) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", n, exp_lat); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL basic_data: got %h want a5", rx_data); end
    n_cmp++; if ({rx_perr, rx_ferr} !== 2'b00) begin n_bad++; $display("FAIL basic_flags: got %b want 00", {rx_perr, rx_ferr}); end
    accept();
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL basic_accept: valid got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL basic_hold: data got %h want a5", rx_data); end
  endtask

  task automatic test_parity();
    logic p;
    bit ok;
    logic [7:0] ed;
    logic ep;
    set_cfg(7, 1, 1, 1, 3);
    for (int k = 0; k < 2; k++) begin
      hold_line(1'b1, 2 * cur_t);
      send_frame(8'h35, 7, 1, 1, 1, (k == 0), 0, p);
      ed = model_data(8'h35, 7);
      ep = model_perr(ed, 1, 1, p);
      wait_valid(4 * cur_t + 20, ok);
      $display("7E2 rx %h perr=%0d ferr=%0d", rx_data, rx_perr, rx_ferr);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL par_timeout: valid got 0 want 1"); end
      n_cmp++; if ({rx_data, rx_perr, rx_ferr} !== {ed, ep, 1'b0}) begin
        n_bad++; $display("FAIL par_7e2_%0d: got %h/%b/%b want %h/%b/0", k, rx_data, rx_perr, rx_ferr, ed, ep);
      end
      accept();
    end
    set_cfg(5, 1, 0, 0, 3);
    hold_line(1'b1, 2 * cur_t);
    send_frame(8'h1F, 5, 1, 0, 0, 0, 0, p);
    ep = model_perr(model_data(8'h1F, 5), 1, 0, p);
    wait_valid(4 * cur_t + 20, ok);
    $display("5O1 rx %h perr=%0d ferr=%0d", rx_data, rx_perr, rx_ferr);
    n_cmp++; if ({ok, rx_data, rx_perr, rx_ferr} !== {1'b1, 8'h1F, ep, 1'b0}) begin
      n_bad++; $display("FAIL par_5o1: got %b/%h/%b/%b want 1/1f/%b/0", ok, rx_data, rx_perr, rx_ferr, ep);
    end
    accept();
  endtask

  task automatic test_framing();
    logic p;
    bit ok;
    set_cfg(8, 0, 0, 0, 3);
    hold_line(1'b1, 2 * cur_t);
    send_frame(8'h3C, 8, 0, 0, 0, 0, 1, p);
    wait_valid(4 * cur_t + 20, ok);
    $display("ferr rx %h perr=%0d ferr=%0d", rx_data, rx_perr, rx_ferr);
    n_cmp++; if ({ok, rx_data, rx_perr, rx_ferr} !== {1'b1, 8'h3C, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL ferr_3c: got %b/%h/%b/%b want 1/3c/0/1", ok, rx_data, rx_perr, rx_ferr);
    end
    accept();
    hold_line(1'b1, 2 * cur_t);
    send_frame(8'h55, 8, 0, 0, 0, 0, 0, p);
    wait_valid(4 * cur_t + 20, ok);
    $display("after ferr rx %h perr=%0d ferr=%0d", rx_data, rx_perr, rx_ferr);
    n_cmp++; if ({ok, rx_data, rx_perr, rx_ferr} !== {1'b1, 8'h55, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL ferr_next55: got %b/%h/%b/%b want 1/55/0/0", ok, rx_data, rx_perr, rx_ferr);
    end
    accept();
    // Break: one all-zero character with a framing error, then no retrigger while low
    set_cfg(8, 0, 0, 0, 1);
    hold_line(1'b1, 2 * cur_t);
    hold_line(1'b0, 20 * cur_t);
    $display("break rx %h ferr=%0d", rx_data, rx_ferr);
    n_cmp++; if ({rx_valid, rx_data, rx_ferr} !== {1'b1, 8'h00, 1'b1}) begin
      n_bad++; $display("FAIL break_char: got %b/%h/%b want 1/00/1", rx_valid, rx_data, rx_ferr);
    end
    accept();
    hold_line(1'b0, 12 * cur_t);
    n_cmp++; if ({rx_valid, rx_busy} !== 2'b00) begin
      n_bad++; $display("FAIL break_retrigger: valid/busy got %b want 00", {rx_valid, rx_busy});
    end
    hold_line(1'b1, 2 * cur_t);
  endtask

  task automatic test_overrun();
    logic p;
    bit ok;
    int ovr0;
    set_cfg(8, 0, 0, 0, 2);
    hold_line(1'b1, 2 * cur_t);
    ovr0 = ovr_cnt;
    send_frame(8'h11, 8, 0, 0, 0, 0, 0, p);
    hold_line(1'b1, cur_t);
    send_frame(8'h22, 8, 0, 0, 0, 0, 0, p);
    hold_line(1'b1, 2 * cur_t);
    $display("overrun rx %h valid=%0d pulses=%0d", rx_data, rx_valid, ovr_cnt - ovr0);
    n_cmp++; if (ovr_cnt - ovr0 != 1) begin n_bad++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt - ovr0); end
    n_cmp++; if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin
      n_bad++; $display("FAIL ovr_held: got %b/%h want 1/11", rx_valid, rx_data);
    end
    accept();
    hold_line(1'b1, 4 * cur_t);
    n_cmp++; if ({rx_valid, rx_data} !== {1'b0, 8'h11}) begin
      n_bad++; $display("FAIL ovr_lost22: got %b/%h want 0/11", rx_valid, rx_data);
    end
  endtask

  task automatic test_back_to_back();
    logic p;
    bit ok;
    int ovr0;
    set_cfg(8, 0, 0, 0, 2);
    hold_line(1'b1, 2 * cur_t);
    send_frame(8'h33, 8, 0, 0, 0, 0, 0, p);
    wait_valid(4 * cur_t + 20, ok);
    hold_line(1'b1, cur_t);
    ovr0 = ovr_cnt;
    // Accept the held character in exactly the cycle the next one is delivered
    fork
      send_frame(8'h44, 8, 0, 0, 0, 0, 0, p);
      begin
        repeat (cur_h + 3 + 9 * cur_t + MAJ) @(negedge mclk);
        rx_ready = 1'b1;
        @(negedge mclk);
        rx_ready = 1'b0;
      end
    join
    $display("b2b rx %h valid=%0d", rx_data, rx_valid);
    n_cmp++; if ({ok, rx_valid, rx_data} !== {1'b1, 1'b1, 8'h44}) begin
      n_bad++; $display("FAIL b2b_load: got %b/%b/%h want 1/1/44", ok, rx_valid, rx_data);
    end
    n_cmp++; if (ovr_cnt != ovr0) begin n_bad++; $display("FAIL b2b_overrun: got %0d want 0", ovr_cnt - ovr0); end
    accept();
  endtask

  task automatic test_false_start();
    bit seen_busy;
    bit seen_valid;
    set_cfg(8, 0, 0, 0, 7);
    hold_line(1'b1, 2 * cur_t);
    seen_busy = 0;
    seen_valid = 0;
    rxd = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge mclk);
      if (i == 3) rxd = 1'b1;
      if (rx_busy === 1'b1) seen_busy = 1;
      if (rx_valid === 1'b1) seen_valid = 1;
    end
    $display("false start busy_seen=%0d valid_seen=%0d", seen_busy, seen_valid);
    n_cmp++; if (seen_busy !== 1'b1) begin n_bad++; $display("FAIL fs_busy_seen: got %b want 1", seen_busy); end
    n_cmp++; if ({seen_valid, rx_busy} !== 2'b00) begin
      n_bad++; $display("FAIL fs_outcome: valid_seen/busy got %b want 00", {seen_valid, rx_busy});
    end
  endtask

  task automatic test_glitch();
    bit ok;
    logic [7:0] exp_d;
    exp_d = (MAJ == 1) ? 8'h00 : 8'h04;
    set_cfg(8, 0, 0, 0, 3);
    hold_line(1'b1, 2 * cur_t);
    hold_line(1'b0, 3 * cur_t);
    hold_line(1'b0, cur_h + 1);
    hold_line(1'b1, 1);
    hold_line(1'b0, cur_t - cur_h - 2);
    hold_line(1'b0, 5 * cur_t);
    hold_line(1'b1, cur_t);
    wait_valid(4 * cur_t + 20, ok);
    $display("glitch rx %h ferr=%0d", rx_data, rx_ferr);
    n_cmp++; if ({ok, rx_data, rx_ferr} !== {1'b1, exp_d, 1'b0}) begin
      n_bad++; $display("FAIL glitch: got %b/%h/%b want 1/%h/0", ok, rx_data, rx_ferr, exp_d);
    end
    accept();
  endtask

  task automatic test_reset_midframe();
    logic p;
    bit ok;
    set_cfg(8, 0, 0, 0, 3);
    hold_line(1'b1, 2 * cur_t);
    send_frame(8'h5A, 8, 0, 0, 0, 0, 0, p);
    wait_valid(4 * cur_t + 20, ok);
    hold_line(1'b1, cur_t);
    fork
      send_frame(8'hF0, 8, 0, 0, 0, 0, 0, p);
      begin
        repeat (5 * cur_t + 2) @(negedge mclk);
        n_cmp++; if (rx_busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy: got %b want 1", rx_busy); end
        rst = 1'b1;
        repeat (2) @(negedge mclk);
        n_cmp++; if ({rx_data, rx_valid, rx_perr, rx_ferr, rx_overrun, rx_busy} !== 13'd0) begin
          n_bad++; $display("FAIL rstmid_outputs: got %b want 0", {rx_data, rx_valid, rx_perr, rx_ferr, rx_overrun, rx_busy});
        end
        rst = 1'b0;
      end
    join
    hold_line(1'b1, 2 * cur_t);
    n_cmp++; if ({rx_valid, rx_busy} !== 2'b00) begin
      n_bad++; $display("FAIL rstmid_after: valid/busy got %b want 00", {rx_valid, rx_busy});
    end
  endtask

  task automatic test_disable_midframe();
    logic p;
    bit ok;
    set_cfg(8, 0, 0, 0, 3);
    hold_line(1'b1, 2 * cur_t);
    send_frame(8'h96, 8, 0, 0, 0, 0, 0, p);
    wait_valid(4 * cur_t + 20, ok);
    hold_line(1'b1, cur_t);
    fork
      send_frame(8'hF0, 8, 0, 0, 0, 0, 0, p);
      begin
        repeat (5 * cur_t + 2) @(negedge mclk);
        cfg_en = 1'b0;
        @(negedge mclk);
        n_cmp++; if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL dis_busy: got %b want 0", rx_busy); end
      end
    join
    cfg_en = 1'b1;
    hold_line(1'b1, 2 * cur_t);
    $display("disable held rx %h valid=%0d", rx_data, rx_valid);
    n_cmp++; if ({ok, rx_valid, rx_data} !== {1'b1, 1'b1, 8'h96}) begin
      n_bad++; $display("FAIL dis_held: got %b/%b/%h want 1/1/96", ok, rx_valid, rx_data);
    end
    accept();
    send_frame(8'hC3, 8, 0, 0, 0, 0, 0, p);
    wait_valid(4 * cur_t + 20, ok);
    $display("after disable rx %h perr=%0d ferr=%0d", rx_data, rx_perr, rx_ferr);
    n_cmp++; if ({ok, rx_data, rx_perr, rx_ferr} !== {1'b1, 8'hC3, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL dis_nextc3: got %b/%h/%b/%b want 1/c3/0/0", ok, rx_data, rx_perr, rx_ferr);
    end
    accept();
  endtask

  task automatic test_random();
    int nbits;
    int div;
    bit par_en, even, two_stop, bad_par, bad_stop;
    logic [7:0] d;
    logic [7:0] ed;
    logic ep;
    logic p;
    bit ok;
    for (int k = 0; k < 12; k++) begin
      nbits    = 5 + int'($urandom_range(3));
      div      = int'($urandom_range(4));
      par_en   = 1'($urandom);
      even     = 1'($urandom);
      two_stop = 1'($urandom);
      bad_par  = par_en & 1'($urandom);
      bad_stop = ($urandom_range(3) == 0);
      d        = 8'($urandom);
      set_cfg(nbits, par_en, even, two_stop, div);
      hold_line(1'b1, 2 * cur_t);
      send_frame(d, nbits, par_en, even, two_stop, bad_par, bad_stop, p);
      ed = model_data(d, nbits);
      ep = model_perr(ed, par_en, even, p);
      wait_valid(4 * cur_t + 20, ok);
      $display("rand %0d: %0d%s%0d div=%0d rx %h perr=%0d ferr=%0d", k, nbits,
               par_en ? (even ? "E" : "O") : "N", two_stop ? 2 : 1, div, rx_data, rx_perr, rx_ferr);
      n_cmp++; if ({ok, rx_data, rx_perr, rx_ferr} !== {1'b1, ed, ep, bad_stop}) begin
        n_bad++; $display("FAIL rand_%0d: got %b/%h/%b/%b want 1/%h/%b/%b", k, ok, rx_data, rx_perr, rx_ferr,
                          ed, ep, bad_stop);
      end
      accept();
    end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_parity();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_false_start();
    test_glitch();
    test_reset_midframe();
    test_disable_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
